// File: rtl/apb_sched_pkg.sv
// apb_sched_pkg: shared state type, bus widths and counter sizing for the APB request scheduler
package apb_sched_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_e;
    localparam int APB_AW = 8;
    localparam int APB_DW = 8;
    // wait counter only has to reach TIMEOUT-1
    function automatic int tmo_cw(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction
endpackage

// File: rtl/apb_req_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or above ptr_i wrapping modulo N
// ports: req_i request vector, ptr_i search start, any_o some request set, idx_o winner index, onehot_o winner one-hot
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);
    always_comb begin
        logic [IW-1:0] j;
        idx_o = '0;
        j = '0;
        // walk from the farthest candidate back so the closest one to ptr wins
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            idx_o = req_i[j] ? j : idx_o;
        end
    end
    assign any_o = |req_i;
    assign onehot_o = any_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/apb_req_scheduler.sv
// apb_req_scheduler: round-robin arbiter sequencing single-beat requests from N requesters onto one APB bus
// ports: PCLK/PRST clock and sync reset; REQ/REQ_WR/REQ_ADDR/REQ_DATA requester side; GNT/DONE/RDATA/ERR responses;
//        PSEL/PEN/PWR/PADDR/PWDAT APB master outputs; PRDY/PRDAT slave responses
module apb_req_scheduler
    import apb_sched_pkg::*;
#(
    parameter int N         = 4,
    parameter int TIMEOUT   = 16,
    parameter int RDATA_LAT = 1
) (
    input  logic                PCLK,
    input  logic                PRST,
    input  logic [N-1:0]        REQ,
    input  logic [N-1:0]        REQ_WR,
    input  logic [APB_AW*N-1:0] REQ_ADDR,
    input  logic [APB_DW*N-1:0] REQ_DATA,
    output logic [N-1:0]        GNT,
    output logic [N-1:0]        DONE,
    output logic [APB_DW-1:0]   RDATA,
    output logic                ERR,
    output logic                PSEL,
    output logic                PEN,
    output logic                PWR,
    output logic [APB_AW-1:0]   PADDR,
    output logic [APB_DW-1:0]   PWDAT,
    input  logic                PRDY,
    input  logic [APB_DW-1:0]   PRDAT
);
    localparam int IW = $clog2(N);
    localparam int CW = tmo_cw(TIMEOUT);
    state_e state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, w_q, w_d, pick_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] gnt_q, gnt_d, done_q, done_d, pick_oh, w_oh;
    logic [APB_DW-1:0] rdata_q, rdata_d, pwdat_q, pwdat_d;
    logic [APB_AW-1:0] paddr_q, paddr_d;
    logic err_q, err_d, pwr_q, pwr_d, pick_any, tmo;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx),
        .onehot_o(pick_oh)
    );

    assign w_oh = N'(1) << w_q;
    // last tolerated low-PRDY cycle; a zero TIMEOUT never aborts
    assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        pwr_d   = pwr_q;
        paddr_d = paddr_q;
        pwdat_d = pwdat_q;
        case (state_q)
            IDLE: if (pick_any) begin
                state_d = SETUP;
                w_d     = pick_idx;
                gnt_d   = pick_oh;
                ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                pwr_d   = REQ_WR[pick_idx];
                paddr_d = APB_AW'(REQ_ADDR >> (pick_idx * APB_AW));
                pwdat_d = APB_DW'(REQ_DATA >> (pick_idx * APB_DW));
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: if (PRDY) begin
                state_d = (pwr_q || RDATA_LAT == 0) ? IDLE : CAPTURE;
                done_d  = (pwr_q || RDATA_LAT == 0) ? w_oh : '0;
                rdata_d = (!pwr_q && RDATA_LAT == 0) ? PRDAT : rdata_q;
            end else if (tmo) begin
                state_d = IDLE;
                done_d  = w_oh;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            CAPTURE: begin
                state_d = IDLE;
                done_d  = w_oh;
                rdata_d = PRDAT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            pwr_q   <= 1'b0;
            paddr_q <= '0;
            pwdat_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            pwr_q   <= pwr_d;
            paddr_q <= paddr_d;
            pwdat_q <= pwdat_d;
        end
    end

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;
    assign PSEL  = (state_q == SETUP) || (state_q == ACCESS);
    assign PEN   = state_q == ACCESS;
    assign PWR   = pwr_q;
    assign PADDR = paddr_q;
    assign PWDAT = pwdat_q;
endmodule

// File: tb/tb_apb_req_scheduler.sv
// tb_apb_req_scheduler: randomized and directed checks of the APB request scheduler against a transaction-level model
module tb_apb_req_scheduler;
    localparam int N = 4;
    localparam int TIMEOUT = 16;
    localparam int BW = 8 * N;
    logic PCLK = 1'b0;
    logic PRST = 1'b1;
    logic [N-1:0] REQ = '0, REQ_WR = '0;
    logic [BW-1:0] REQ_ADDR = '0, REQ_DATA = '0;
    logic [N-1:0] GNT, DONE;
    logic [7:0] RDATA, PADDR, PWDAT, PRDAT;
    logic ERR, PSEL, PEN, PWR, PRDY;
    int total = 0, bad = 0;

    always #5 PCLK = ~PCLK;

    apb_req_scheduler #(.N(N), .TIMEOUT(TIMEOUT), .RDATA_LAT(1)) dut (
        .PCLK(PCLK), .PRST(PRST), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .PSEL(PSEL), .PEN(PEN), .PWR(PWR),
        .PADDR(PADDR), .PWDAT(PWDAT), .PRDY(PRDY), .PRDAT(PRDAT)
    );

    // slave: ws wait states per access, read data registered one cycle after the ready edge
    logic [7:0] smem [0:255];
    bit sv [0:255];
    int acc = 0, ws = 0, ws_next = 0;
    bit stall = 1'b0;
    assign PRDY = PSEL && PEN && !stall && (acc >= ws);
    always @(posedge PCLK) begin
        acc <= (PSEL && PEN && !PRDY) ? acc + 1 : 0;
        if (PSEL && PEN && PRDY && PWR) begin
            smem[PADDR] <= PWDAT;
            sv[PADDR] <= 1'b1;
        end
        PRDAT <= (PSEL && PEN && PRDY && !PWR) ? (sv[PADDR] ? smem[PADDR] : PADDR ^ 8'h5A) : 8'($urandom);
    end

    // transaction-level reference: one transfer in flight, latency from wait states
    logic [7:0] ref_mem [0:255];
    int n = 0, m_ptr = 0, m_w = 0, m_done_n = 0, m_g_n = 0;
    bit m_busy = 1'b0, m_wr = 1'b0, m_tmo = 1'b0;
    logic [7:0] m_addr = '0, m_data = '0;
    logic [N-1:0] exp_gnt = '0, exp_done = '0;
    logic exp_err = 1'b0, exp_psel = 1'b0, exp_pen = 1'b0, exp_pwr = 1'b0, exp_rchk = 1'b0;
    logic [7:0] exp_rdata = '0, exp_paddr = '0, exp_pwdat = '0;

    function automatic logic [N-1:0] bitm(input int i);
        return N'(1) << i;
    endfunction

    task automatic tick();
        logic [N-1:0] r, wr;
        logic [BW-1:0] a, d;
        bit rst, st;
        int w;
        r = REQ; wr = REQ_WR; a = REQ_ADDR; d = REQ_DATA; rst = PRST; st = stall; w = 0;
        @(negedge PCLK);
        n++;
        exp_gnt = '0; exp_done = '0; exp_err = 1'b0; exp_rchk = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0;
            exp_rdata = '0; exp_paddr = '0; exp_pwdat = '0; exp_pwr = 1'b0;
        end else if (m_busy && n == m_done_n) begin
            m_busy = 1'b0;
            exp_done = bitm(m_w);
            exp_rchk = !m_wr || m_tmo;
            if (m_tmo) begin exp_err = 1'b1; exp_rdata = '0; end
            else if (m_wr) ref_mem[m_addr] = m_data;
            else exp_rdata = ref_mem[m_addr];
        end else if (!m_busy && r != '0) begin
            for (int k = N - 1; k >= 0; k--)
                if (((int'(r) >> ((m_ptr + k) % N)) & 1) == 1) w = (m_ptr + k) % N;
            exp_gnt = bitm(w);
            m_ptr = (w + 1) % N;
            m_busy = 1'b1; m_w = w; m_g_n = n; m_tmo = st;
            m_wr = (wr & bitm(w)) != '0;
            m_addr = 8'(a >> (8 * w));
            m_data = 8'(d >> (8 * w));
            ws = ws_next;
            m_done_n = st ? n + 1 + TIMEOUT : n + 2 + ws + (m_wr ? 0 : 1);
            exp_paddr = m_addr; exp_pwdat = m_data; exp_pwr = m_wr;
        end
        exp_psel = m_busy && !(!m_wr && !m_tmo && n == m_done_n - 1);
        exp_pen = exp_psel && n > m_g_n;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
        REQ = REQ | bitm(i);
        REQ_WR = wr ? (REQ_WR | bitm(i)) : (REQ_WR & ~bitm(i));
        REQ_ADDR = (REQ_ADDR & ~(BW'(8'hFF) << (8 * i))) | (BW'(a) << (8 * i));
        REQ_DATA = (REQ_DATA & ~(BW'(8'hFF) << (8 * i))) | (BW'(d) << (8 * i));
    endtask

    task automatic clr_req(input int i);
        REQ = REQ & ~bitm(i);
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && m_busy; c++) tick();
        tick();
    endtask

    task automatic test_reset();
        PRST = 1'b1;
        tick();
        tick();
        total++;
        if ({GNT, DONE, ERR, PSEL, PEN, PWR} !== '0) begin
            bad++; $display("FAIL reset_ctrl got %b want 0", {GNT, DONE, ERR, PSEL, PEN, PWR});
        end
        total++;
        if ({PADDR, PWDAT, RDATA} !== '0) begin
            bad++; $display("FAIL reset_data got %h want 0", {PADDR, PWDAT, RDATA});
        end
        PRST = 1'b0;
    endtask

    task automatic test_single_write();
        ws_next = 0;
        set_req(2, 1'b1, 8'h10, 8'hA5);
        tick();
        total++;
        if (GNT !== 4'b0100) begin bad++; $display("FAIL sw_gnt got %b want 0100", GNT); end
        total++;
        if ({PSEL, PEN, PWR, PADDR, PWDAT} !== {3'b101, 8'h10, 8'hA5}) begin
            bad++; $display("FAIL sw_setup got %b %h %h want 101 10 a5", {PSEL, PEN, PWR}, PADDR, PWDAT);
        end
        clr_req(2);
        tick();
        total++;
        if ({PSEL, PEN} !== 2'b11) begin bad++; $display("FAIL sw_access got %b want 11", {PSEL, PEN}); end
        tick();
        total++;
        if (DONE !== 4'b0100 || ERR !== 1'b0) begin bad++; $display("FAIL sw_done got %b err %b want 0100 0", DONE, ERR); end
        set_req(2, 1'b0, 8'h10, 8'h00);
        tick();
        clr_req(2);
        tick();
        tick();
        total++;
        if (DONE !== '0 || PSEL !== 1'b0) begin bad++; $display("FAIL rb_capture got done %b psel %b want 0 0", DONE, PSEL); end
        tick();
        total++;
        if (DONE !== 4'b0100 || RDATA !== 8'hA5) begin bad++; $display("FAIL rb_done got %b %h want 0100 a5", DONE, RDATA); end
        drain();
    endtask

    task automatic test_read_lat();
        ws_next = 0;
        set_req(0, 1'b0, 8'h33, 8'h00);
        tick();
        total++;
        if (GNT !== 4'b0001) begin bad++; $display("FAIL rd_gnt got %b want 0001", GNT); end
        clr_req(0);
        tick();
        tick();
        total++;
        if (DONE !== '0) begin bad++; $display("FAIL rd_early got %b want 0", DONE); end
        tick();
        total++;
        if (DONE !== 4'b0001 || ERR !== 1'b0 || RDATA !== (8'h33 ^ 8'h5A)) begin
            bad++; $display("FAIL rd_done got %b %b %h want 0001 0 %h", DONE, ERR, RDATA, 8'h33 ^ 8'h5A);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int start, got, low;
        start = m_ptr; got = 0; low = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
        for (int c = 0; c < 100 && got < 2 * N; c++) begin
            ws_next = $urandom_range(0, 2);
            tick();
            if (GNT != '0) begin
                total++;
                if (GNT !== bitm((start + got) % N) || GNT !== exp_gnt) begin
                    bad++; $display("FAIL rr_order got %b want %b", GNT, bitm((start + got) % N));
                end
                if (got > 0) begin
                    total++;
                    if (low != 1) begin bad++; $display("FAIL rr_gap got %0d idle cycles want 1", low); end
                end
                got++; low = 0;
                set_req(m_w, 1'b1, 8'($urandom), 8'($urandom));
            end else if (!PSEL) low++;
        end
        total++;
        if (got != 2 * N) begin bad++; $display("FAIL rr_count got %0d grants want %0d", got, 2 * N); end
        REQ = '0;
        drain();
    endtask

    task automatic test_timeout();
        int accs, dc;
        accs = 0; dc = -1;
        stall = 1'b1;
        set_req(3, 1'b0, 8'h44, 8'h00);
        tick();
        total++;
        if (GNT !== 4'b1000) begin bad++; $display("FAIL tmo_gnt got %b want 1000", GNT); end
        clr_req(3);
        for (int c = 1; c <= 30 && dc < 0; c++) begin
            tick();
            if (PSEL && PEN) accs++;
            if (DONE != '0) dc = c;
        end
        total++;
        if (accs != TIMEOUT) begin bad++; $display("FAIL tmo_cycles got %0d want %0d", accs, TIMEOUT); end
        total++;
        if (DONE !== 4'b1000 || ERR !== 1'b1 || RDATA !== 8'h00 || PSEL !== 1'b0) begin
            bad++; $display("FAIL tmo_done got %b err %b rdata %h psel %b want 1000 1 00 0", DONE, ERR, RDATA, PSEL);
        end
        stall = 1'b0;
        tick();
        total++;
        if (ERR !== 1'b0 || DONE !== '0) begin bad++; $display("FAIL tmo_pulse got err %b done %b want 0 0", ERR, DONE); end
        drain();
    endtask

    task automatic test_reset_mid();
        int dn;
        dn = 0;
        stall = 1'b1;
        set_req(1, 1'b1, 8'h55, 8'h66);
        tick();
        clr_req(1);
        tick();
        tick();
        tick();
        total++;
        if (PEN !== 1'b1) begin bad++; $display("FAIL rm_access got pen %b want 1", PEN); end
        PRST = 1'b1;
        tick();
        PRST = 1'b0;
        stall = 1'b0;
        total++;
        if ({PSEL, PEN, GNT, DONE} !== '0) begin bad++; $display("FAIL rm_clear got %b want 0", {PSEL, PEN, GNT, DONE}); end
        for (int c = 0; c < 24; c++) begin
            tick();
            if (DONE != '0 || PSEL) dn++;
        end
        total++;
        if (dn != 0) begin bad++; $display("FAIL rm_quiet got %0d active cycles want 0", dn); end
    endtask

    task automatic test_rearm();
        ws_next = 0;
        set_req(1, 1'b1, 8'h21, 8'h12);
        set_req(3, 1'b1, 8'h23, 8'h32);
        tick();
        total++;
        if (GNT !== 4'b0010) begin bad++; $display("FAIL ra_ptr0 got %b want 0010", GNT); end
        clr_req(1);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (DONE != '0) break;
        end
        total++;
        if (DONE !== 4'b0010) begin bad++; $display("FAIL ra_done got %b want 0010", DONE); end
        set_req(1, 1'b1, 8'h31, 8'h13);
        tick();
        total++;
        if (GNT !== 4'b1000) begin bad++; $display("FAIL ra_first got %b want 1000", GNT); end
        clr_req(3);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (GNT != '0) break;
        end
        total++;
        if (GNT !== 4'b0010) begin bad++; $display("FAIL ra_next got %b want 0010", GNT); end
        clr_req(1);
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ws_next = $urandom_range(0, 3);
            for (int i = 0; i < N; i++)
                if ((REQ & bitm(i)) == '0 && $urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            tick();
            total++;
            if (GNT !== exp_gnt || DONE !== exp_done || ERR !== exp_err) begin
                bad++; $display("FAIL rnd_hs n=%0d got %b %b %b want %b %b %b", n, GNT, DONE, ERR, exp_gnt, exp_done, exp_err);
            end
            total++;
            if ({PSEL, PEN} !== {exp_psel, exp_pen}) begin
                bad++; $display("FAIL rnd_bus n=%0d got %b want %b", n, {PSEL, PEN}, {exp_psel, exp_pen});
            end
            total++;
            if ({PWR, PADDR, PWDAT} !== {exp_pwr, exp_paddr, exp_pwdat}) begin
                bad++; $display("FAIL rnd_attr n=%0d got %b %h %h want %b %h %h", n, PWR, PADDR, PWDAT, exp_pwr, exp_paddr, exp_pwdat);
            end
            if (exp_rchk) begin
                total++;
                if (RDATA !== exp_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, RDATA, exp_rdata); end
            end
            if (exp_gnt != '0) clr_req(m_w);
        end
        REQ = '0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_single_write();
        test_read_lat();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_rearm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
